// File: rtl/slave_port_pkg.sv
// rtl/slave_port_pkg.sv - shared types and bus constants for the serial bus slave port
package slave_port_pkg;

  localparam int BUS_ADDR_BITS = 16;
  localparam int BUS_DATA_BITS = 8;
  localparam int CNT_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    MEM_WR,
    MEM_RD,
    RDATA
  } state_e;

endpackage

// File: rtl/slave_port_if.sv
// rtl/slave_port_if.sv - serial system bus signals between master/decoder and a slave port
interface slave_port_if;
  logic sel;
  logic mode;
  logic wr_bus;
  logic master_valid;
  logic slave_ready;
  logic rd_bus;
  logic slave_valid;
  logic master_ready;
  logic split;

  modport master (
    output sel, mode, wr_bus, master_valid, master_ready,
    input  slave_ready, rd_bus, slave_valid, split
  );

  modport slave (
    input  sel, mode, wr_bus, master_valid, master_ready,
    output slave_ready, rd_bus, slave_valid, split
  );
endinterface

// File: rtl/slave_port_bus_shift_reg.sv
// rtl/slave_port_bus_shift_reg.sv - enable-gated shift register, serial-in/parallel-out and parallel-load/serial-out
module bus_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         shift_en_i,
  input  logic         load_en_i,
  input  logic         serial_i,
  input  logic [W-1:0] load_data_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Parallel load wins over shift so a read capture never races a stray shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           data_q <= '0;
    else if (load_en_i)  data_q <= load_data_i;
    else if (shift_en_i) data_q <= {data_q[W-2:0], serial_i};
  end

  assign q_o = data_q;

endmodule

// File: rtl/slave_port.sv
// rtl/slave_port.sv - serial bus responder: address/data deserialiser, memory strobes, read serialiser
// Optional read split request enabled by defining SLAVE_PORT_SPLIT_EN.
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  slave_port_if.slave              bus,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [BUS_DATA_BITS-1:0] s_wr_data,
  output logic                     s_wr_en,
  output logic                     s_rd_en,
  input  logic [BUS_DATA_BITS-1:0] s_rd_data
);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(BUS_ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BUS_DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(RD_LATENCY);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  s_addr_q;
  logic [ADDR_W-2:0]  addr_shift;
  logic [BUS_DATA_BITS-1:0] rd_shift;
  logic               addr_shift_en, addr_load, wr_shift_en, rd_load, rd_shift_en;
  logic               in_xfer, out_xfer;
  logic               rd_unused;

  assign bus.slave_ready = rstn & bus.sel &
                           (state_q == IDLE || state_q == ADDR || state_q == WDATA);
  assign bus.slave_valid = (state_q == RDATA);
  assign bus.rd_bus      = rd_shift[BUS_DATA_BITS-1];
  assign in_xfer         = bus.sel & bus.master_valid & bus.slave_ready;
  assign out_xfer        = bus.slave_valid & bus.master_ready;
  assign s_wr_en         = (state_q == MEM_WR);
  assign s_rd_en         = (state_q == MEM_RD) && (cnt_q == '0);
  assign s_addr          = s_addr_q;
  assign rd_unused       = ^rd_shift[BUS_DATA_BITS-2:0];

`ifdef SLAVE_PORT_SPLIT_EN
  assign bus.split = (RD_LATENCY > 1) && (state_q == MEM_RD);
`else
  assign bus.split = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (addr_load) s_addr_q <= {addr_shift, bus.wr_bus};
    end
  end

  // cnt_q doubles as the address/data bit counter and the read wait counter.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_shift_en = 1'b0;
    addr_load     = 1'b0;
    wr_shift_en   = 1'b0;
    rd_load       = 1'b0;
    rd_shift_en   = 1'b0;
    case (state_q)
      IDLE: if (in_xfer) begin
        addr_shift_en = 1'b1;
        cnt_d         = CNT_W'(1);
        state_d       = ADDR;
      end
      ADDR: if (!bus.sel) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else if (in_xfer) begin
        addr_shift_en = 1'b1;
        if (cnt_q == ADDR_LAST) begin
          addr_load = 1'b1;
          cnt_d     = '0;
          state_d   = bus.mode ? WDATA : MEM_RD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WDATA: if (!bus.sel) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else if (in_xfer) begin
        wr_shift_en = 1'b1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = MEM_WR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEM_WR: state_d = IDLE;
      MEM_RD: if (cnt_q == LAT_LAST) begin
        rd_load = 1'b1;
        cnt_d   = '0;
        state_d = RDATA;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RDATA: if (out_xfer) begin
        rd_shift_en = 1'b1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  bus_shift_reg #(.W(ADDR_W - 1)) u_addr_sr (
    .clk(clk), .rstn(rstn), .shift_en_i(addr_shift_en), .load_en_i(1'b0),
    .serial_i(bus.wr_bus), .load_data_i('0), .q_o(addr_shift)
  );

  bus_shift_reg #(.W(BUS_DATA_BITS)) u_wr_sr (
    .clk(clk), .rstn(rstn), .shift_en_i(wr_shift_en), .load_en_i(1'b0),
    .serial_i(bus.wr_bus), .load_data_i('0), .q_o(s_wr_data)
  );

  bus_shift_reg #(.W(BUS_DATA_BITS)) u_rd_sr (
    .clk(clk), .rstn(rstn), .shift_en_i(rd_shift_en), .load_en_i(rd_load),
    .serial_i(1'b0), .load_data_i(s_rd_data), .q_o(rd_shift)
  );

endmodule

// File: tb/tb_slave_port.sv
// tb/tb_slave_port.sv - directed table-driven bench for slave_port
module tb_slave_port;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] s_addr;
  logic [7:0]  s_wr_data;
  logic        s_wr_en, s_rd_en;
  logic [7:0]  s_rd_data;
  logic [7:0]  mem_val = 8'h00;
  logic [15:0] rd_pipe;
  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_pulses = 0;
  int          rd_pulses = 0;

  slave_port_if bus ();

  slave_port #(.ADDR_W(12), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .s_addr(s_addr), .s_wr_data(s_wr_data),
    .s_wr_en(s_wr_en), .s_rd_en(s_rd_en), .s_rd_data(s_rd_data)
  );

  always #5 clk = ~clk;

  // Memory model: data is valid only in the cycle exactly RD_LAT after the strobe.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) rd_pipe <= '0;
    else       rd_pipe <= {rd_pipe[14:0], s_rd_en};
  end
  assign s_rd_data = rd_pipe[RD_LAT-1] ? mem_val : 8'hE7;

  always @(posedge clk) begin
    if (s_wr_en) wr_pulses++;
    if (s_rd_en) rd_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_addr(input logic [15:0] addr, input logic md, output int rdy_bad);
    rdy_bad = 0;
    bus.sel  = 1'b1;
    bus.mode = md;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.wr_bus       = addr[15-i];
      bus.master_valid = 1'b1;
      if (bus.slave_ready !== 1'b1) rdy_bad++;
    end
  endtask

  task automatic do_write(input string tag, input logic [15:0] addr, input logic [7:0] data,
                          input logic [11:0] exp_addr);
    int rdy_bad;
    int wp0;
    wp0 = wr_pulses;
    send_addr(addr, 1'b1, rdy_bad);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.wr_bus = data[7-i];
      if (bus.slave_ready !== 1'b1) rdy_bad++;
    end
    @(negedge clk);
    bus.master_valid = 1'b0;
    bus.sel          = 1'b0;
    chk({tag, " wr_ready"}, rdy_bad, 0);
    chk({tag, " s_wr_en"}, s_wr_en, 1);
    chk({tag, " s_wr_data"}, s_wr_data, data);
    chk({tag, " s_addr"}, s_addr, exp_addr);
    @(negedge clk);
    chk({tag, " wr_pulses"}, wr_pulses - wp0, 1);
  endtask

  task automatic do_read(input string tag, input logic [15:0] addr, input logic [7:0] data,
                         input bit toggle, input logic [11:0] exp_addr);
    int rdy_bad, n, k, nb, hold_bad, split_bad, rp0;
    logic [7:0] got;
    logic held;
    bit have_hold;
    rp0 = rd_pulses;
    mem_val = data;
    send_addr(addr, 1'b0, rdy_bad);
    @(negedge clk);
    bus.master_valid = 1'b0;
    chk({tag, " rd_addr_ready"}, rdy_bad, 0);
    chk({tag, " s_rd_en"}, s_rd_en, 1);
    chk({tag, " s_addr"}, s_addr, exp_addr);
    chk({tag, " ready_in_memrd"}, bus.slave_ready, 0);
    bus.sel = 1'b0;
    n = 0;
    split_bad = 0;
    while (!bus.slave_valid && n < 40) begin
`ifdef SLAVE_PORT_SPLIT_EN
      if (bus.split !== (RD_LAT > 1)) split_bad++;
`else
      if (bus.split !== 1'b0) split_bad++;
`endif
      n++;
      @(negedge clk);
    end
    chk({tag, " rd_latency"}, n, RD_LAT + 1);
    chk({tag, " split_memrd"}, split_bad, 0);
    chk({tag, " split_rdata"}, bus.split, 0);
    got = '0; nb = 0; k = 0; hold_bad = 0; have_hold = 0; held = 1'b0;
    while (nb < 8 && k < 40) begin
      if (have_hold && bus.rd_bus !== held) hold_bad++;
      bus.master_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (bus.slave_valid && bus.master_ready) begin
        got = {got[6:0], bus.rd_bus};
        nb++;
        have_hold = 0;
      end else begin
        held = bus.rd_bus;
        have_hold = 1;
      end
      @(negedge clk);
      k++;
    end
    bus.master_ready = 1'b0;
    chk({tag, " rd_bits"}, nb, 8);
    chk({tag, " rd_byte"}, got, data);
    chk({tag, " rd_cycles"}, k, toggle ? 15 : 8);
    chk({tag, " rd_hold"}, hold_bad, 0);
    chk({tag, " idle_after_rd"}, bus.slave_valid, 0);
    chk({tag, " rd_pulses"}, rd_pulses - rp0, 1);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          toggle;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int wp0, rp0, rdy_bad;
    vecs[0] = '{1'b1, 16'h0A5C, 8'hC3, 1'b0, 12'hA5C};
    vecs[1] = '{1'b0, 16'h0123, 8'h96, 1'b0, 12'h123};
    vecs[2] = '{1'b0, 16'h8F00, 8'h3C, 1'b1, 12'hF00};
    vecs[3] = '{1'b1, 16'hF123, 8'hA5, 1'b0, 12'h123};
    vecs[4] = '{1'b0, 16'hFFFF, 8'h81, 1'b1, 12'hFFF};

    bus.sel = 1'b1; bus.mode = 1'b0; bus.wr_bus = 1'b0;
    bus.master_valid = 1'b0; bus.master_ready = 1'b0;
    @(negedge clk);
    chk("reset slave_ready", bus.slave_ready, 0);
    chk("reset slave_valid", bus.slave_valid, 0);
    chk("reset rd_bus", bus.rd_bus, 0);
    chk("reset split", bus.split, 0);
    chk("reset strobes", {s_wr_en, s_rd_en}, 0);
    chk("reset s_addr", s_addr, 0);
    chk("reset s_wr_data", s_wr_data, 0);
    bus.sel = 1'b0;
    rstn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].wr) do_write($sformatf("vec%0d", v), vecs[v].addr, vecs[v].data, vecs[v].exp_addr);
      else do_read($sformatf("vec%0d", v), vecs[v].addr, vecs[v].data, vecs[v].toggle, vecs[v].exp_addr);
    end

    // Abort after 6 address bits, then a full write must line up from bit 0.
    wp0 = wr_pulses; rp0 = rd_pulses;
    bus.sel = 1'b1; bus.mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.wr_bus = i[0];
      bus.master_valid = 1'b1;
    end
    @(negedge clk);
    bus.sel = 1'b0; bus.master_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort no strobe", (wr_pulses - wp0) + (rd_pulses - rp0), 0);
    do_write("after_abort", 16'h0001, 8'h7E, 12'h001);

    // Reset after 3 data bits of a write: outputs clear at once, write discarded.
    wp0 = wr_pulses;
    send_addr(16'h0ABC, 1'b1, rdy_bad);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.wr_bus = 1'b1;
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst slave_ready", bus.slave_ready, 0);
    chk("midrst s_addr", s_addr, 0);
    chk("midrst s_wr_data", s_wr_data, 0);
    chk("midrst strobes", {s_wr_en, s_rd_en, bus.slave_valid}, 0);
    bus.sel = 1'b0; bus.master_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst no wr_en", wr_pulses - wp0, 0);
    do_write("after_reset", 16'h0FFF, 8'h01, 12'hFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
